// File: rtl/risc_v_alu_pipe_pkg.sv
// Opcode patterns, op/state enums and the instruction decoder for risc_v_alu_pipe.
// M-extension patterns decode only when RV_M_EXT_EN is defined.
package risc_v_alu_pipe_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef logic [31:0] instruction_t;

  typedef enum logic {IDLE, DIV} alu_state_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_LUI, OP_AUIPC,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILL
  } alu_op_t;

  localparam instruction_t M_ADD    = 32'b0000000_?????_?????_000_?????_0110011;
  localparam instruction_t M_SUB    = 32'b0100000_?????_?????_000_?????_0110011;
  localparam instruction_t M_SLL    = 32'b0000000_?????_?????_001_?????_0110011;
  localparam instruction_t M_SLT    = 32'b0000000_?????_?????_010_?????_0110011;
  localparam instruction_t M_SLTU   = 32'b0000000_?????_?????_011_?????_0110011;
  localparam instruction_t M_XOR    = 32'b0000000_?????_?????_100_?????_0110011;
  localparam instruction_t M_SRL    = 32'b0000000_?????_?????_101_?????_0110011;
  localparam instruction_t M_SRA    = 32'b0100000_?????_?????_101_?????_0110011;
  localparam instruction_t M_OR     = 32'b0000000_?????_?????_110_?????_0110011;
  localparam instruction_t M_AND    = 32'b0000000_?????_?????_111_?????_0110011;
  localparam instruction_t M_LUI    = 32'b????????????????????_?????_0110111;
  localparam instruction_t M_AUIPC  = 32'b????????????????????_?????_0010111;
  localparam instruction_t M_MUL    = 32'b0000001_?????_?????_000_?????_0110011;
  localparam instruction_t M_MULH   = 32'b0000001_?????_?????_001_?????_0110011;
  localparam instruction_t M_MULHSU = 32'b0000001_?????_?????_010_?????_0110011;
  localparam instruction_t M_MULHU  = 32'b0000001_?????_?????_011_?????_0110011;
  localparam instruction_t M_DIV    = 32'b0000001_?????_?????_100_?????_0110011;
  localparam instruction_t M_DIVU   = 32'b0000001_?????_?????_101_?????_0110011;
  localparam instruction_t M_REM    = 32'b0000001_?????_?????_110_?????_0110011;
  localparam instruction_t M_REMU   = 32'b0000001_?????_?????_111_?????_0110011;

  // Patterns are mutually exclusive, so match order does not matter.
  function automatic alu_op_t decode_op(input instruction_t i);
    alu_op_t op;
    op = OP_ILL;
    if (i ==? M_ADD)    op = OP_ADD;
    if (i ==? M_SUB)    op = OP_SUB;
    if (i ==? M_SLL)    op = OP_SLL;
    if (i ==? M_SLT)    op = OP_SLT;
    if (i ==? M_SLTU)   op = OP_SLTU;
    if (i ==? M_XOR)    op = OP_XOR;
    if (i ==? M_SRL)    op = OP_SRL;
    if (i ==? M_SRA)    op = OP_SRA;
    if (i ==? M_OR)     op = OP_OR;
    if (i ==? M_AND)    op = OP_AND;
    if (i ==? M_LUI)    op = OP_LUI;
    if (i ==? M_AUIPC)  op = OP_AUIPC;
`ifdef RV_M_EXT_EN
    if (i ==? M_MUL)    op = OP_MUL;
    if (i ==? M_MULH)   op = OP_MULH;
    if (i ==? M_MULHSU) op = OP_MULHSU;
    if (i ==? M_MULHU)  op = OP_MULHU;
    if (i ==? M_DIV)    op = OP_DIV;
    if (i ==? M_DIVU)   op = OP_DIVU;
    if (i ==? M_REM)    op = OP_REM;
    if (i ==? M_REMU)   op = OP_REMU;
`endif
    return op;
  endfunction

endpackage

// File: rtl/risc_v_alu_pipe_if.sv
// Request/result handshake bundle between decode and the ALU execution unit.
interface risc_v_alu_pipe_if #(parameter int unsigned XLEN = 32) ();
  import risc_v_alu_pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  instruction_t      instr;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic              zero_flag;
  logic              illegal;

  modport master (
    output in_valid, instr, rs1_val, rs2_val, pc, out_ready,
    input  in_ready, out_valid, result, zero_flag, illegal
  );

  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, pc, out_ready,
    output in_ready, out_valid, result, zero_flag, illegal
  );
endinterface

// File: rtl/risc_v_alu_pipe_div.sv
// Radix-2 restoring divider: XLEN iterations on operand magnitudes, then
// combinational sign fixup and divide-by-zero / overflow overrides while done.
module risc_v_div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_signed,
  input  logic            i_rem,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_neg_q, r_neg_r, r_rem, r_div0, r_ovf;
  logic [XLEN-1:0] r_quot, r_part, r_divisor, r_dividend;
  logic            w_a_neg, w_b_neg;
  logic [XLEN:0]   w_shift, w_diff;
  logic [XLEN-1:0] w_q, w_r;

  assign w_a_neg = i_signed && i_dividend[XLEN-1];
  assign w_b_neg = i_signed && i_divisor[XLEN-1];
  assign w_shift = {r_part, r_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy     <= 1'b1;
      r_cnt      <= CW'(XLEN);
      r_part     <= '0;
      r_quot     <= w_a_neg ? -i_dividend : i_dividend;
      r_divisor  <= w_b_neg ? -i_divisor : i_divisor;
      r_dividend <= i_dividend;
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_rem      <= i_rem;
      r_div0     <= (i_divisor == '0);
      r_ovf      <= i_signed && (i_dividend == {1'b1, {(XLEN-1){1'b0}}}) && (i_divisor == '1);
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
        if (!w_diff[XLEN]) begin
          r_part <= w_diff[XLEN-1:0];
          r_quot <= {r_quot[XLEN-2:0], 1'b1};
        end else begin
          r_part <= w_shift[XLEN-1:0];
          r_quot <= {r_quot[XLEN-2:0], 1'b0};
        end
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  always_comb begin
    w_q = r_neg_q ? -r_quot : r_quot;
    w_r = r_neg_r ? -r_part : r_part;
    if (r_div0) begin
      w_q = '1;
      w_r = r_dividend;
    end else if (r_ovf) begin
      w_q = {1'b1, {(XLEN-1){1'b0}}};
      w_r = '0;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_busy && (r_cnt == '0);
  assign o_result = r_rem ? w_r : w_q;
endmodule

// File: rtl/risc_v_alu_pipe.sv
// RV32I/RV64I ALU with a registered valid/ready result stage.
// Define RV_M_EXT_EN to add single-cycle multiply and the iterative divider.
module risc_v_alu_pipe
  import risc_v_alu_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic              clk,
  input logic              rst_n,
  risc_v_alu_pipe_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  if (XLEN != 32 && XLEN != XLEN_MAX) begin : g_xlen_chk
    $error("risc_v_alu_pipe: XLEN must be 32 or 64");
  end

  alu_state_t      r_state, w_state_nxt;
  logic            r_out_valid, r_zero, r_illegal;
  logic [XLEN-1:0] r_result;
  alu_op_t         w_op;
  logic            w_accept, w_is_div, w_illegal, w_div_done;
  logic [XLEN-1:0] w_res, w_upimm, w_div_res;
  logic [SHW-1:0]  w_shamt;

  assign w_op         = decode_op(bus.instr);
  assign bus.in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_is_div     = w_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign w_illegal    = (w_op == OP_ILL);
  assign w_shamt      = bus.rs2_val[SHW-1:0];
  assign w_upimm      = XLEN'($signed({bus.instr[31:12], 12'b0}));

`ifdef RV_M_EXT_EN
  logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
  logic              w_a_sgn, w_b_sgn, w_div_busy;

  // One 2*XLEN multiplier covers all signedness mixes via operand extension.
  assign w_a_sgn = (w_op == OP_MULH) || (w_op == OP_MULHSU);
  assign w_b_sgn = (w_op == OP_MULH);
  assign w_mul_a = {{XLEN{w_a_sgn & bus.rs1_val[XLEN-1]}}, bus.rs1_val};
  assign w_mul_b = {{XLEN{w_b_sgn & bus.rs2_val[XLEN-1]}}, bus.rs2_val};
  assign w_prod  = w_mul_a * w_mul_b;

  risc_v_div_iter #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_accept && w_is_div),
    .i_dividend (bus.rs1_val),
    .i_divisor  (bus.rs2_val),
    .i_signed   ((w_op == OP_DIV) || (w_op == OP_REM)),
    .i_rem      ((w_op == OP_REM) || (w_op == OP_REMU)),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_result   (w_div_res)
  );

  always_ff @(posedge clk) begin
    if (rst_n && r_state == IDLE) assert (!w_div_busy) else $error("divider busy while IDLE");
  end
`else
  assign w_div_done = 1'b0;
  assign w_div_res  = '0;
`endif

  always_comb begin
    w_res = '0;
    case (w_op)
      OP_ADD:   w_res = bus.rs1_val + bus.rs2_val;
      OP_SUB:   w_res = bus.rs1_val - bus.rs2_val;
      OP_SLL:   w_res = bus.rs1_val << w_shamt;
      OP_SRL:   w_res = bus.rs1_val >> w_shamt;
      OP_SRA:   w_res = $unsigned($signed(bus.rs1_val) >>> w_shamt);
      OP_SLT:   w_res = XLEN'($signed(bus.rs1_val) < $signed(bus.rs2_val));
      OP_SLTU:  w_res = XLEN'(bus.rs1_val < bus.rs2_val);
      OP_XOR:   w_res = bus.rs1_val ^ bus.rs2_val;
      OP_OR:    w_res = bus.rs1_val | bus.rs2_val;
      OP_AND:   w_res = bus.rs1_val & bus.rs2_val;
      OP_LUI:   w_res = w_upimm;
      OP_AUIPC: w_res = bus.pc + w_upimm;
`ifdef RV_M_EXT_EN
      OP_MUL:   w_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_prod[2*XLEN-1:XLEN];
`endif
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_div) w_state_nxt = DIV;
      DIV:     if (w_div_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A divide accept only drains the output stage; its result lands on done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept && !w_is_div) begin
      assert (!w_illegal) else $warning("risc_v_alu_pipe: unsupported instr 0x%h", bus.instr);
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_zero      <= (w_res == '0);
      r_illegal   <= w_illegal;
    end else if (w_div_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_div_res;
      r_zero      <= (w_div_res == '0);
      r_illegal   <= 1'b0;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero_flag = r_zero;
  assign bus.illegal   = r_illegal;
endmodule
